seq_mult_worker: RTL

Shift-and-add multiplier that serves as the job-executing end of the start/done handshake driven by the `fsm_controller` sequencer. It takes a one-cycle `start`, runs for a bounded number of cycles, and answers with a one-cycle `done` pulse and a registered product. It also gives the team a real worker to close the loop against the controller in system benches.

---
 rtl/seq_mult_worker.sv | 115 +++++++++++
 1 files changed

// File: rtl/seq_mult_worker.sv
// Shift-and-add unsigned multiplier worker answering a one-cycle start with a one-cycle done.
// Optional SEQ_MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module seq_mult_worker #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      mcand_q, mcand_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PW-1:0]      acc_sum;
  logic [WIDTH-1:0]   mplier_shift;
  logic               last_step;

  // One multiplier bit retired per RUN cycle.
  always_comb begin
    acc_sum      = acc_q + (mplier_q[0] ? mcand_q : PW'(0));
    mplier_shift = mplier_q >> 1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    last_step    = (cnt_q == CNT_W'(WIDTH - 1)) || (mplier_shift == WIDTH'(0));
`else
    last_step    = (cnt_q == CNT_W'(WIDTH - 1));
`endif
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = PW'(0);
          cnt_d    = CNT_W'(0);
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shift;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_step) begin
          product_d = acc_sum;
          state_d   = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
